avalon_arb_2x1: RTL and testbench
=================================

Name: avalon_arb_2x1

Overview:
- Two-master, one-slave arbiter for the team's simple Avalon-style request/ready/read-valid interface.
- Lets two requesters, such as a CNN feature-map DMA and the HPS-side configuration master, share one memory-mapped slave, such as the SDRAM bridge.
- Provides round-robin grant with a lock held until the slave accepts the command.
- Tracks outstanding reads in an ID FIFO so in-order read responses are routed back to the issuing master.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width on all ports.
- MAX_PENDING, 8, depth of the outstanding-read ID FIFO; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_address / m1_address  in  ADDR_WIDTH  per-master address.
- m0_write_data / m1_write_data  in  DATA_WIDTH  per-master write data.
- m0_write_req / m1_write_req  in  1  write request; held until the matching mN_ready.
- m0_read_req / m1_read_req  in  1  read request; held until the matching mN_ready.
- m0_ready / m1_ready  out  1  command accepted this cycle.
- m0_read_data / m1_read_data  out  DATA_WIDTH  both driven from slave_read_data.
- m0_read_data_valid / m1_read_data_valid  out  1  response valid for that master.
- slave_address  out  ADDR_WIDTH  owner's address while granted, else 0.
- slave_write_data  out  DATA_WIDTH  owner's write data while granted, else 0.
- slave_write_req  out  1  owner's write request while granted.
- slave_read_req  out  1  owner's read request while granted and the FIFO is not full.
- slave_ready  in  1  slave accepts the presented command this cycle.
- slave_read_data  in  DATA_WIDTH  read response data.
- slave_read_data_valid  in  1  read response strobe; responses arrive in issue order.
- pending_reads  out  clog2(MAX_PENDING)+1  current FIFO occupancy.
- err_unexpected_rdv  out  1  sticky; set by a read response that arrives while the FIFO is empty.

Behaviour:
- Reset state:
  - All outputs 0 and state IDLE.
  - last_grant = 1, so master 0 wins the first tie.
  - FIFO empty, pending_reads = 0, err_unexpected_rdv = 0.
  - Reset mid-operation discards the FIFO contents and any lock.
- State machine: IDLE and GRANT(owner), with owner ∈ {0,1}.
- IDLE:
  - Slave request and address outputs are 0; m0_ready = m1_ready = 0.
  - reqN = mN_write_req | mN_read_req.
  - If only one master requests, go to GRANT with that master as owner.
  - If both request, owner = ~last_grant.
  - If neither requests, stay in IDLE.
- GRANT(owner):
  - slave_address, slave_write_data and slave_write_req mirror the owner's inputs.
  - slave_read_req = owner read_req & ~fifo_full.
  - m<owner>_ready = slave_ready & (owner write_req | (owner read_req & ~fifo_full)).
  - The other master's ready is 0.
- Acceptance = m<owner>_ready high:
  - Next state is IDLE; last_grant <= owner.
  - A read acceptance pushes owner into the FIFO.
  - Peak throughput is therefore one command per 2 cycles.
- Owner drops both requests while in GRANT (protocol violation): return to IDLE; last_grant and FIFO unchanged; nothing pushed.
- Owner asserts write_req and read_req together: only the write is forwarded; slave_read_req = 0.
- FIFO full while the owner is reading: stall with slave_read_req = 0 and ready = 0, and stay in GRANT until a pop frees an entry. The other master is not granted meanwhile.
- Response routing:
  - On slave_read_data_valid with the FIFO non-empty, pop the head ID.
  - mN_read_data_valid = slave_read_data_valid & (head == N), combinational, zero latency.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- slave_read_data_valid with the FIFO empty:
  - No mN_read_data_valid is asserted and the data is dropped.
  - err_unexpected_rdv <= 1 and stays set until reset.
- Pointers are log2(MAX_PENDING) bits and wrap modulo MAX_PENDING. Full/empty are derived from the count.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to 0x100 with slave_ready = 1: GRANT0 the next cycle, slave_write_req = 1 with address 0x100, m0_ready for one cycle, back to IDLE; m1_ready stays 0.
- m0 and m1 both hold read_req continuously with slave_ready = 1: grants alternate 0,1,0,1; pending_reads goes 1,2,3,4. Four read responses with data 1..4 assert m0_rdv, m1_rdv, m0_rdv, m1_rdv in that order with the matching data.
- Owner m1 in GRANT with slave_ready = 0 for 5 cycles while m0 also requests: the grant stays with m1 and slave_address stays at m1's address; m1 is accepted when slave_ready rises, then m0 is granted.
- MAX_PENDING = 8, issue 8 reads from m0 with no responses: on the 9th read slave_read_req = 0 and m0_ready = 0. One response arrives -> the 9th read is accepted the same cycle it is unblocked, and pending_reads returns to 8.
- Read accept and read response in the same cycle at pending_reads = 3: pending_reads stays 3, and the response routes to the old FIFO head.
- slave_read_data_valid pulse at pending_reads = 0: no mN_read_data_valid is asserted and err_unexpected_rdv = 1 from the next cycle. Asserting rst_n = 0 mid-GRANT clears every output immediately.

Source files
------------

// File: rtl/avalon_arb_2x1.sv
// Two-master, one-slave arbiter for the request/ready/read-valid interface.
// Round-robin grant locked until accept; a read-ID FIFO routes in-order responses.
module avalon_arb_2x1 #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MAX_PENDING = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   // master 0
   input  logic [ADDR_WIDTH-1:0]          m0_address,
   input  logic [DATA_WIDTH-1:0]          m0_write_data,
   input  logic                           m0_write_req,
   input  logic                           m0_read_req,
   output logic                           m0_ready,
   output logic [DATA_WIDTH-1:0]          m0_read_data,
   output logic                           m0_read_data_valid,
   // master 1
   input  logic [ADDR_WIDTH-1:0]          m1_address,
   input  logic [DATA_WIDTH-1:0]          m1_write_data,
   input  logic                           m1_write_req,
   input  logic                           m1_read_req,
   output logic                           m1_ready,
   output logic [DATA_WIDTH-1:0]          m1_read_data,
   output logic                           m1_read_data_valid,
   // slave
   output logic [ADDR_WIDTH-1:0]          slave_address,
   output logic [DATA_WIDTH-1:0]          slave_write_data,
   output logic                           slave_write_req,
   output logic                           slave_read_req,
   input  logic                           slave_ready,
   input  logic [DATA_WIDTH-1:0]          slave_read_data,
   input  logic                           slave_read_data_valid,
   // status
   output logic [$clog2(MAX_PENDING):0]   pending_reads,
   output logic                           err_unexpected_rdv
);

   localparam int unsigned PtrW = $clog2(MAX_PENDING);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_grant_q, last_grant_d;

   logic [MAX_PENDING-1:0] id_mem_q;
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q, count_d;
   logic                   err_q;

   logic req0, req1;
   logic own_wr, own_rd;
   logic fifo_full, fifo_empty;
   logic accept, push, pop, head;

   assign req0       = m0_write_req | m0_read_req;
   assign req1       = m1_write_req | m1_read_req;
   assign own_wr     = owner_q ? m1_write_req : m0_write_req;
   assign own_rd     = owner_q ? m1_read_req  : m0_read_req;
   assign fifo_full  = (count_q == CntW'(MAX_PENDING));
   assign fifo_empty = (count_q == '0);

   // Arbitration FSM: next state and slave-side outputs
   always_comb begin
      state_d          = state_q;
      owner_d          = owner_q;
      last_grant_d     = last_grant_q;
      slave_address    = '0;
      slave_write_data = '0;
      slave_write_req  = 1'b0;
      slave_read_req   = 1'b0;
      m0_ready         = 1'b0;
      m1_ready         = 1'b0;
      accept           = 1'b0;
      push             = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 && req1) begin
               state_d = StGrant;
               owner_d = ~last_grant_q;
            end else if (req0) begin
               state_d = StGrant;
               owner_d = 1'b0;
            end else if (req1) begin
               state_d = StGrant;
               owner_d = 1'b1;
            end
         end
         StGrant: begin
            slave_address    = owner_q ? m1_address : m0_address;
            slave_write_data = owner_q ? m1_write_data : m0_write_data;
            slave_write_req  = own_wr;
            // A simultaneous write wins; the read is never forwarded with it.
            slave_read_req   = own_rd & ~own_wr & ~fifo_full;
            accept           = slave_ready & (own_wr | (own_rd & ~fifo_full));
            m0_ready         = accept & ~owner_q;
            m1_ready         = accept & owner_q;
            if (accept) begin
               state_d      = StIdle;
               last_grant_d = owner_q;
               push         = ~own_wr & own_rd;
            end else if (!own_wr && !own_rd) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Read-ID FIFO and response routing
   assign pop  = slave_read_data_valid & ~fifo_empty;
   assign head = id_mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_mem_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            id_mem_q[wr_ptr_q] <= owner_q;
            wr_ptr_q           <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
         if (slave_read_data_valid && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign m0_read_data       = slave_read_data;
   assign m1_read_data       = slave_read_data;
   assign m0_read_data_valid = pop & ~head;
   assign m1_read_data_valid = pop & head;
   assign pending_reads      = count_q;
   assign err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_avalon_arb_2x1.sv
// Self-checking bench for avalon_arb_2x1: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_avalon_arb_2x1;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MP = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] m0_address, m1_address;
   logic [DW-1:0] m0_write_data, m1_write_data;
   logic          m0_write_req, m0_read_req, m1_write_req, m1_read_req;
   logic          m0_ready, m1_ready;
   logic [DW-1:0] m0_read_data, m1_read_data;
   logic          m0_read_data_valid, m1_read_data_valid;
   logic [AW-1:0] slave_address;
   logic [DW-1:0] slave_write_data;
   logic          slave_write_req, slave_read_req, slave_ready;
   logic [DW-1:0] slave_read_data;
   logic          slave_read_data_valid;
   logic [$clog2(MP):0] pending_reads;
   logic          err_unexpected_rdv;

   avalon_arb_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .m0_address            (m0_address),
      .m0_write_data         (m0_write_data),
      .m0_write_req          (m0_write_req),
      .m0_read_req           (m0_read_req),
      .m0_ready              (m0_ready),
      .m0_read_data          (m0_read_data),
      .m0_read_data_valid    (m0_read_data_valid),
      .m1_address            (m1_address),
      .m1_write_data         (m1_write_data),
      .m1_write_req          (m1_write_req),
      .m1_read_req           (m1_read_req),
      .m1_ready              (m1_ready),
      .m1_read_data          (m1_read_data),
      .m1_read_data_valid    (m1_read_data_valid),
      .slave_address         (slave_address),
      .slave_write_data      (slave_write_data),
      .slave_write_req       (slave_write_req),
      .slave_read_req        (slave_read_req),
      .slave_ready           (slave_ready),
      .slave_read_data       (slave_read_data),
      .slave_read_data_valid (slave_read_data_valid),
      .pending_reads         (pending_reads),
      .err_unexpected_rdv    (err_unexpected_rdv)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who holds the bus (-1 = nobody), rotation memory, issued-read IDs.
   int m_owner;
   bit m_last;
   bit m_q[$];
   bit m_err;

   typedef struct {
      bit          rst;
      bit          w0, r0, w1, r1, sr, srdv;
      logic [31:0] rdata;
      bit          e_rdy0, e_rdy1, e_swr, e_srd;
      logic [31:0] e_addr;
      bit          e_rdv0, e_rdv1;
      int          e_pend;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input bit rst, w0, r0, w1, r1, sr, srdv,
                               input logic [31:0] rdata,
                               input bit er0, er1, eswr, esrd,
                               input logic [31:0] ea,
                               input bit ev0, ev1, input int ep);
      vec_t v;
      v.rst = rst; v.w0 = w0; v.r0 = r0; v.w1 = w1; v.r1 = r1; v.sr = sr; v.srdv = srdv;
      v.rdata = rdata; v.e_rdy0 = er0; v.e_rdy1 = er1; v.e_swr = eswr; v.e_srd = esrd;
      v.e_addr = ea; v.e_rdv0 = ev0; v.e_rdv1 = ev1; v.e_pend = ep;
      tbl.push_back(v);
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1'b1;
      m_q.delete();
      m_err   = 1'b0;
   endtask

   task automatic set_in(input bit w0, r0, w1, r1, sr, srdv, input logic [31:0] rd);
      m0_write_req = w0; m0_read_req = r0;
      m1_write_req = w1; m1_read_req = r1;
      slave_ready = sr; slave_read_data_valid = srdv; slave_read_data = rd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {m0_ready, m1_ready}, 0);
      chk({tag, "_slave_req"}, {slave_write_req, slave_read_req}, 0);
      chk({tag, "_slave_address"}, slave_address, 0);
      chk({tag, "_slave_write_data"}, slave_write_data, 0);
      chk({tag, "_rdv"}, {m0_read_data_valid, m1_read_data_valid}, 0);
      chk({tag, "_pending"}, pending_reads, 0);
      chk({tag, "_err"}, err_unexpected_rdv, 0);
   endtask

   // Compare every output against the model, advance the model, then step one clock.
   task automatic cyc();
      bit            granted, full, own_wr, own_rd, acc, pop, r0, r1;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      #1;
      granted = (m_owner >= 0);
      full    = (m_q.size() == MP);
      own_wr  = granted && ((m_owner == 1) ? m1_write_req : m0_write_req);
      own_rd  = granted && ((m_owner == 1) ? m1_read_req : m0_read_req);
      e_addr  = !granted ? '0 : ((m_owner == 1) ? m1_address : m0_address);
      e_wd    = !granted ? '0 : ((m_owner == 1) ? m1_write_data : m0_write_data);
      acc     = slave_ready && (own_wr || (own_rd && !full));
      pop     = slave_read_data_valid && (m_q.size() > 0);
      chk("m0_ready", m0_ready, acc && m_owner == 0);
      chk("m1_ready", m1_ready, acc && m_owner == 1);
      chk("slave_address", slave_address, e_addr);
      chk("slave_write_data", slave_write_data, e_wd);
      chk("slave_write_req", slave_write_req, own_wr);
      chk("slave_read_req", slave_read_req, own_rd && !own_wr && !full);
      chk("m0_rdv", m0_read_data_valid, pop && m_q[0] == 1'b0);
      chk("m1_rdv", m1_read_data_valid, pop && m_q[0] == 1'b1);
      chk("m0_read_data", m0_read_data, slave_read_data);
      chk("m1_read_data", m1_read_data, slave_read_data);
      chk("pending_reads", pending_reads, m_q.size());
      chk("err_unexpected_rdv", err_unexpected_rdv, m_err);
      if (slave_read_data_valid) begin
         if (m_q.size() > 0) void'(m_q.pop_front());
         else m_err = 1'b1;
      end
      if (!granted) begin
         r0 = m0_write_req || m0_read_req;
         r1 = m1_write_req || m1_read_req;
         if (r0 && r1) m_owner = m_last ? 0 : 1;
         else if (r0) m_owner = 0;
         else if (r1) m_owner = 1;
      end else if (acc) begin
         if (!own_wr) m_q.push_back(m_owner[0]);
         m_last  = m_owner[0];
         m_owner = -1;
      end else if (!own_wr && !own_rd) begin
         m_owner = -1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0, '0);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      m0_address = 32'h100; m0_write_data = 32'hDEADBEEF;
      m1_address = 32'h200; m1_write_data = 32'h12345678;
      set_in(0, 0, 0, 0, 0, 0, '0);

      // rst w0 r0 w1 r1 sr srdv rdata | rdy0 rdy1 swr srd addr rdv0 rdv1 pend
      add(0, 1,0,0,0, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 0);
      add(0, 1,0,0,0, 1,0, 0,  1,0,1,0, 32'h100, 0,0, 0);
      add(0, 0,0,0,0, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 0);
      add(1, 0,0,0,0, 0,0, 0,  0,0,0,0, 32'h000, 0,0, 0);
      add(0, 0,1,0,1, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 0);
      add(0, 0,1,0,1, 1,0, 0,  1,0,0,1, 32'h100, 0,0, 0);
      add(0, 0,1,0,1, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 1);
      add(0, 0,1,0,1, 1,0, 0,  0,1,0,1, 32'h200, 0,0, 1);
      add(0, 0,1,0,1, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 2);
      add(0, 0,1,0,1, 1,0, 0,  1,0,0,1, 32'h100, 0,0, 2);
      add(0, 0,1,0,1, 1,0, 0,  0,0,0,0, 32'h000, 0,0, 3);
      add(0, 0,1,0,1, 1,0, 0,  0,1,0,1, 32'h200, 0,0, 3);
      add(0, 0,0,0,0, 0,1, 1,  0,0,0,0, 32'h000, 1,0, 4);
      add(0, 0,0,0,0, 0,1, 2,  0,0,0,0, 32'h000, 0,1, 3);
      add(0, 0,0,0,0, 0,1, 3,  0,0,0,0, 32'h000, 1,0, 2);
      add(0, 0,0,0,0, 0,1, 4,  0,0,0,0, 32'h000, 0,1, 1);
      add(0, 0,0,0,0, 0,0, 0,  0,0,0,0, 32'h000, 0,0, 0);

      do_reset();
      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            do_reset();
         end else begin
            set_in(tbl[i].w0, tbl[i].r0, tbl[i].w1, tbl[i].r1, tbl[i].sr, tbl[i].srdv,
                   tbl[i].rdata);
            #1;
            chk($sformatf("vec%0d_ready", i), {m0_ready, m1_ready},
                {tbl[i].e_rdy0, tbl[i].e_rdy1});
            chk($sformatf("vec%0d_slave_req", i), {slave_write_req, slave_read_req},
                {tbl[i].e_swr, tbl[i].e_srd});
            chk($sformatf("vec%0d_slave_address", i), slave_address, tbl[i].e_addr);
            chk($sformatf("vec%0d_rdv", i), {m0_read_data_valid, m1_read_data_valid},
                {tbl[i].e_rdv0, tbl[i].e_rdv1});
            chk($sformatf("vec%0d_pending", i), pending_reads, tbl[i].e_pend);
            if (tbl[i].e_rdv0 || tbl[i].e_rdv1)
               chk($sformatf("vec%0d_rdata", i),
                   tbl[i].e_rdv0 ? m0_read_data : m1_read_data, tbl[i].rdata);
            cyc();
         end
      end

      // Locked grant: m1 stalls on slave_ready while m0 waits.
      do_reset();
      set_in(0, 0, 1, 0, 0, 0, '0);
      cyc();
      set_in(1, 0, 1, 0, 0, 0, '0);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("lock_address", slave_address, 32'h200);
         chk("lock_ready", {m0_ready, m1_ready}, 2'b00);
         cyc();
      end
      set_in(1, 0, 1, 0, 1, 0, '0);
      #1;
      chk("lock_release_m1", {m0_ready, m1_ready}, 2'b01);
      cyc();
      set_in(1, 0, 0, 0, 1, 0, '0);
      cyc();
      #1;
      chk("lock_then_m0", {m0_ready, m1_ready}, 2'b10);
      cyc();

      // FIFO full: ninth read stalls until one response frees an entry.
      do_reset();
      set_in(0, 1, 0, 0, 1, 0, '0);
      repeat (16) cyc();
      cyc();
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("full_stall_srd", slave_read_req, 1'b0);
         chk("full_stall_ready", m0_ready, 1'b0);
         chk("full_pending", pending_reads, 8);
         cyc();
      end
      set_in(0, 1, 0, 0, 1, 1, 32'h55);
      #1;
      chk("full_pop_rdv0", m0_read_data_valid, 1'b1);
      chk("full_pop_ready", m0_ready, 1'b0);
      cyc();
      set_in(0, 1, 0, 0, 1, 0, '0);
      #1;
      chk("full_unblock_srd", slave_read_req, 1'b1);
      chk("full_unblock_ready", m0_ready, 1'b1);
      cyc();
      set_in(0, 0, 0, 0, 0, 0, '0);
      #1;
      chk("full_refill_pending", pending_reads, 8);
      cyc();
      set_in(0, 0, 0, 0, 0, 1, 32'h66);
      repeat (8) cyc();

      // Push and pop in the same cycle at occupancy 3; response goes to the old head.
      do_reset();
      set_in(0, 1, 0, 0, 1, 0, '0);
      repeat (2) cyc();
      set_in(0, 0, 0, 1, 1, 0, '0);
      repeat (5) cyc();
      set_in(0, 0, 0, 1, 1, 1, 32'h77);
      #1;
      chk("pushpop_pending_before", pending_reads, 3);
      chk("pushpop_accept", m1_ready, 1'b1);
      chk("pushpop_route_head", {m0_read_data_valid, m1_read_data_valid}, 2'b10);
      cyc();
      set_in(0, 0, 0, 0, 0, 0, '0);
      #1;
      chk("pushpop_pending_after", pending_reads, 3);
      cyc();

      // Unexpected response, then asynchronous reset in the middle of a grant.
      do_reset();
      set_in(0, 0, 0, 0, 0, 1, 32'h99);
      #1;
      chk("unexp_rdv", {m0_read_data_valid, m1_read_data_valid}, 2'b00);
      chk("unexp_err_same_cycle", err_unexpected_rdv, 1'b0);
      cyc();
      set_in(0, 0, 0, 0, 0, 0, '0);
      #1;
      chk("unexp_err_sticky", err_unexpected_rdv, 1'b1);
      cyc();
      set_in(1, 0, 0, 0, 0, 0, '0);
      cyc();
      #1;
      chk("midgrant_write_req", slave_write_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midgrant_reset");
      model_reset();
      set_in(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         m0_address    = $urandom;
         m1_address    = $urandom;
         m0_write_data = $urandom;
         m1_write_data = $urandom;
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) != 0,
                (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0),
                $urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
